// File: rtl/alu_sequencer.sv
// Purpose: sequences one ALU instruction through select, execute, write-back and flag capture.
// Latency: outDone 5 cycles after acceptance for binary ops, 4 for unary; illegal flagged after 1 cycle.
// Backpressure: inStart is only honoured in IDLE; requests in any other state are dropped, never queued.
module alu_sequencer (
  input  logic       inCLK,
  input  logic       inRST,
  input  logic       inStart,
  input  logic [7:0] inInstr,
  input  logic       inSignFlag,
  input  logic       inZeroFlag,
  output logic [7:0] outOpcode,
  output logic       outSu,
  output logic       outEnableOut,
  output logic       outLoadTmp,
  output logic       outRegSel,
  output logic       outLoadAcc,
  output logic       outBusy,
  output logic       outDone,
  output logic       outIllegal,
  output logic       outSign,
  output logic       outZero
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    FLAG  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state;
  state_t     nextState;
  logic       isBinary;
  logic       isUnary;
  logic       accept;
  logic [7:0] opcodeReg;
  logic       regSelReg;
  logic       subReg;
  logic       illegalReg;
  logic       signReg;
  logic       zeroReg;

  // Classify the incoming opcode as a two-operand op, a single-operand op, or neither.
  always_comb begin
    isBinary = 1'b0;
    isUnary  = 1'b0;
    case (inInstr)
      8'h80, 8'h81, 8'h90, 8'h91, 8'hA0,
      8'hA1, 8'hA8, 8'hA9, 8'hB0, 8'hB1: isBinary = 1'b1;
      8'h3C, 8'h3D, 8'h17, 8'h1F:        isUnary  = 1'b1;
      default: ;
    endcase
  end

  assign accept = (state == IDLE) && inStart;

  // State register; reset drops straight to IDLE so every strobe dies without waiting for a clock.
  always_ff @(posedge inCLK or posedge inRST) begin
    if (inRST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and Moore output decode; unary ops skip SEL since there is no TMP operand to fetch.
  always_comb begin
    nextState    = state;
    outLoadTmp   = 1'b0;
    outEnableOut = 1'b0;
    outLoadAcc   = 1'b0;
    outBusy      = 1'b1;
    outDone      = 1'b0;
    case (state)
      IDLE: begin
        outBusy = 1'b0;
        if (inStart) begin
          if (isBinary) begin
            nextState = SEL;
          end else if (isUnary) begin
            nextState = EXEC;
          end
        end
      end
      SEL: begin
        outLoadTmp = 1'b1;
        nextState  = EXEC;
      end
      EXEC: begin
        nextState = WRITE;
      end
      WRITE: begin
        outEnableOut = 1'b1;
        outLoadAcc   = 1'b1;
        nextState    = FLAG;
      end
      FLAG: begin
        nextState = DONE;
      end
      DONE: begin
        outDone   = 1'b1;
        nextState = IDLE;
      end
      default: begin
        outBusy   = 1'b0;
        nextState = IDLE;
      end
    endcase
  end

  // Latch the instruction and its derived controls at acceptance; they hold until the next acceptance.
  always_ff @(posedge inCLK or posedge inRST) begin
    if (inRST) begin
      opcodeReg <= 8'h00;
      regSelReg <= 1'b0;
      subReg    <= 1'b0;
    end else if (accept) begin
      opcodeReg <= inInstr;
      regSelReg <= isBinary & inInstr[0];
      subReg    <= isBinary & (inInstr[7:1] == 7'h48);
    end
  end

  // One-cycle illegal pulse: set by an accepted opcode that decodes to nothing, cleared otherwise.
  always_ff @(posedge inCLK or posedge inRST) begin
    if (inRST) begin
      illegalReg <= 1'b0;
    end else begin
      illegalReg <= accept & ~isBinary & ~isUnary;
    end
  end

  // Snapshot the ALU flags on the DONE->IDLE edge, by which point they have settled.
  always_ff @(posedge inCLK or posedge inRST) begin
    if (inRST) begin
      signReg <= 1'b0;
      zeroReg <= 1'b0;
    end else if (state == DONE) begin
      signReg <= inSignFlag;
      zeroReg <= inZeroFlag;
    end
  end

  assign outOpcode  = opcodeReg;
  assign outRegSel  = regSelReg;
  assign outSu      = subReg & (state != IDLE);
  assign outIllegal = illegalReg;
  assign outSign    = signReg;
  assign outZero    = zeroReg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Purpose: directed check of alu_sequencer state sequencing, strobes, flag capture and reset.
// Latency: each step advances one clock and samples 1 time unit after the rising edge.
// Backpressure: none; inStart is driven directly by the stimulus.
module tb_alu_sequencer;

  logic       inCLK;
  logic       inRST;
  logic       inStart;
  logic [7:0] inInstr;
  logic       inSignFlag;
  logic       inZeroFlag;
  logic [7:0] outOpcode;
  logic       outSu;
  logic       outEnableOut;
  logic       outLoadTmp;
  logic       outRegSel;
  logic       outLoadAcc;
  logic       outBusy;
  logic       outDone;
  logic       outIllegal;
  logic       outSign;
  logic       outZero;

  int vectors    = 0;
  int miscompares = 0;
  logic expSign;
  logic expZero;

  // Packed view of the control outputs: busy, done, illegal, loadTmp, regSel, enableOut, loadAcc, su.
  logic [7:0] strobes;
  assign strobes = {outBusy, outDone, outIllegal, outLoadTmp, outRegSel, outEnableOut, outLoadAcc, outSu};

  alu_sequencer dut (
    .inCLK       (inCLK),
    .inRST       (inRST),
    .inStart     (inStart),
    .inInstr     (inInstr),
    .inSignFlag  (inSignFlag),
    .inZeroFlag  (inZeroFlag),
    .outOpcode   (outOpcode),
    .outSu       (outSu),
    .outEnableOut(outEnableOut),
    .outLoadTmp  (outLoadTmp),
    .outRegSel   (outRegSel),
    .outLoadAcc  (outLoadAcc),
    .outBusy     (outBusy),
    .outDone     (outDone),
    .outIllegal  (outIllegal),
    .outSign     (outSign),
    .outZero     (outZero)
  );

  initial inCLK = 1'b0;
  always #5 inCLK = ~inCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge inCLK);
    #1;
  endtask

  // Issue one instruction and walk it through every state, checking strobes, opcode and flags.
  task automatic runOp(input logic [7:0] op, input bit bin, input bit su, input bit rs,
                       input bit sIn, input bit zIn, input bit hold);
    inInstr    = op;
    inStart    = 1'b1;
    inSignFlag = sIn;
    inZeroFlag = zIn;
    step();
    if (!hold) inStart = 1'b0;
    if (bin) begin
      chk("SEL", strobes, {4'b1001, rs, 2'b00, su});
      chk("SEL opcode", outOpcode, op);
      step();
    end
    chk("EXEC", strobes, {4'b1000, rs, 2'b00, su});
    chk("EXEC opcode", outOpcode, op);
    step();
    chk("WRITE", strobes, {4'b1000, rs, 2'b11, su});
    step();
    chk("FLAG", strobes, {4'b1000, rs, 2'b00, su});
    step();
    chk("DONE", strobes, {4'b1100, rs, 2'b00, su});
    chk("DONE old flags", {outSign, outZero}, {expSign, expZero});
    step();
    expSign = sIn;
    expZero = zIn;
    chk("IDLE", strobes, {4'b0000, rs, 3'b000});
    chk("IDLE flags", {outSign, outZero}, {expSign, expZero});
    chk("IDLE opcode", outOpcode, op);
  endtask

  initial begin
    inRST      = 1'b1;
    inStart    = 1'b0;
    inInstr    = 8'h00;
    inSignFlag = 1'b0;
    inZeroFlag = 1'b0;
    expSign    = 1'b0;
    expZero    = 1'b0;

    // Reset state before any clock edge.
    #3;
    chk("reset strobes", strobes, 8'h00);
    chk("reset opcode", outOpcode, 8'h00);
    chk("reset flags", {outSign, outZero}, 2'b00);
    step();
    inRST = 1'b0;

    // ADD with C: SEL with regSel=1, done on cycle 5, su low.
    runOp(8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    // SUB with B: su high SEL..DONE, flags 1/0 captured.
    runOp(8'h90, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // DCR: no SEL, done on cycle 4.
    runOp(8'h3D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // RAL: same timing, opcode 17.
    runOp(8'h17, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Illegal opcode: single illegal pulse, never busy, flags untouched.
    inInstr    = 8'hFF;
    inStart    = 1'b1;
    inSignFlag = 1'b0;
    inZeroFlag = 1'b0;
    step();
    inStart = 1'b0;
    chk("ILL pulse", strobes, 8'b0010_0000);
    chk("ILL opcode", outOpcode, 8'hFF);
    chk("ILL flags", {outSign, outZero}, {expSign, expZero});
    step();
    chk("ILL after", strobes, 8'h00);
    chk("ILL flags after", {outSign, outZero}, {expSign, expZero});

    // XOR after illegal runs normally.
    runOp(8'hA8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // inStart held high with OR: repeats every 6 cycles, starts during SEL..DONE ignored.
    runOp(8'hB0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    runOp(8'hB0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    inStart = 1'b0;
    step();
    chk("hold release idle", strobes, 8'h00);

    // Asynchronous reset during WRITE of ADD B.
    inInstr = 8'h80;
    inStart = 1'b1;
    step();
    inStart = 1'b0;
    chk("RST SEL", strobes, 8'b1001_0000);
    step();
    step();
    chk("RST WRITE", strobes, 8'b1000_0110);
    #2;
    inRST = 1'b1;
    #1;
    chk("RST async strobes", strobes, 8'h00);
    chk("RST async opcode", outOpcode, 8'h00);
    chk("RST async flags", {outSign, outZero}, 2'b00);
    step();
    chk("RST held strobes", strobes, 8'h00);
    inRST   = 1'b0;
    expSign = 1'b0;
    expZero = 1'b0;

    // INR after reset completes in 4 cycles.
    runOp(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: inCLK  in  1  system clock, rising edge.
REQ-002 SHALL have: inRST  in  1  reset; one clock, asynchronous, active-high.
REQ-003 SHALL have: inStart  in  1  request pulse; inInstr valid in the same cycle.
REQ-004 SHALL have: inInstr  in  8  instruction opcode to execute.
REQ-005 SHALL have: inSignFlag, inZeroFlag  in  1 each  ALU flag outputs.
REQ-006 SHALL have: outOpcode  out  8  opcode driven to the ALU.
REQ-007 SHALL have: outSu  out  1  ALU subtract select.
REQ-008 SHALL have: outEnableOut  out  1  ALU result drive-to-bus enable.
REQ-009 SHALL have: outLoadTmp  out  1  load TMP from register file; outRegSel  out  1  0=B, 1=C.
REQ-010 SHALL have: outLoadAcc  out  1  load accumulator from bus.
REQ-011 SHALL have: outBusy, outDone, outIllegal  out  1 each  status; outSign, outZero  out  1 each  captured flags.

Function
REQ-012 SHALL accept inStart only in IDLE; inStart in any other state SHALL be ignored, no queuing.
REQ-013 SHALL latch inInstr on acceptance; outOpcode SHALL hold that value until the next acceptance.
REQ-014 Binary opcodes: 80,81 (ADD), 90,91 (SUB), A0,A1 (AND), A8,A9 (XOR), B0,B1 (OR); bit0 SHALL set outRegSel (0=B, 1=C).
REQ-015 Unary opcodes: 3C (INR), 3D (DCR), 17 (RAL), 1F (RAR); all other values illegal.
REQ-016 States: IDLE, SEL, EXEC, WRITE, FLAG, DONE; outputs SHALL be Moore-decoded from state.
REQ-017 Transitions: IDLE->SEL (binary), IDLE->EXEC (unary), IDLE->IDLE (illegal); SEL->EXEC->WRITE->FLAG->DONE->IDLE unconditionally.
REQ-018 SEL: outLoadTmp=1. EXEC: operands settle, no load strobes. WRITE: outEnableOut=1 and outLoadAcc=1. FLAG: no strobes, ALU flags register.
REQ-019 outSu SHALL be 1 from SEL through DONE for 90/91, else 0.
REQ-020 In DONE, outSign/outZero SHALL be captured from inSignFlag/inZeroFlag at the DONE->IDLE edge; they SHALL hold until the next capture.
REQ-021 outDone SHALL be high exactly one cycle (DONE state); outBusy SHALL be high in every non-IDLE state.
REQ-022 Latency from the accepting edge to outDone: binary 5 cycles, unary 4 cycles.
REQ-023 Illegal opcode: outIllegal SHALL pulse one cycle after the accepting edge; state stays IDLE; no strobes asserted; outSign/outZero unchanged.
REQ-024 Back-to-back: inStart asserted during DONE SHALL be ignored; it SHALL be accepted the following cycle (IDLE).
REQ-025 outLoadTmp, outEnableOut and outLoadAcc SHALL never be high in the same cycle except the WRITE pair.

Reset
REQ-026 Asserting inRST SHALL immediately force IDLE, outOpcode=00, outRegSel=0, and all other outputs 0, independent of inCLK.
REQ-027 Reset mid-operation SHALL abort with no outDone and no further strobes; the first acceptance is allowed on the first rising edge after deassertion.

Verification
REQ-028 Reset, then inStart with inInstr=81 -> SEL (outLoadTmp=1, outRegSel=1), EXEC, WRITE (outEnableOut=outLoadAcc=1), FLAG, outDone on cycle 5; outSu=0 throughout.
REQ-029 inInstr=90 with ALU flags inSignFlag=1, inZeroFlag=0 in DONE -> outSu=1 SEL..DONE; outSign=1, outZero=0 afterwards.
REQ-030 inInstr=3D -> no SEL state, outLoadTmp never 1, outDone on cycle 4; inInstr=17 -> same timing, outOpcode=17.
REQ-031 inInstr=FF -> outIllegal pulse for 1 cycle, outBusy stays 0, no strobes; next inStart with A8 executes normally.
REQ-032 inStart held high continuously with inInstr=B0 -> operations repeat every 6 cycles; inStart seen in SEL..DONE ignored.
REQ-033 inRST asserted asynchronously during WRITE of opcode 80 -> all outputs 0 before the next edge, no outDone; after release, inStart with 3C completes in 4 cycles.
